// File: rtl/avmm_rw_arbiter_if.sv
// Bundled requester-side and memory-side Avalon-MM signals of the read/write arbiter.
// master: the arbiter's view; slave: the surrounding kernels and memory.
interface avmm_rw_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [64*NUM_REQ-1:0] req_address;
    logic [8*NUM_REQ-1:0]  req_byteenable;
    logic [NUM_REQ-1:0]    req_read;
    logic [NUM_REQ-1:0]    req_write;
    logic [64*NUM_REQ-1:0] req_writedata;
    logic [NUM_REQ-1:0]    req_waitrequest;
    logic [63:0]           req_readdata;
    logic [NUM_REQ-1:0]    req_readdatavalid;

    logic [63:0]           avmm_0_rw_address;
    logic [7:0]            avmm_0_rw_byteenable;
    logic                  avmm_0_rw_read;
    logic                  avmm_0_rw_write;
    logic [63:0]           avmm_0_rw_writedata;
    logic [63:0]           avmm_0_rw_readdata;

    logic                  protocol_err;

    modport master (
        input  req_address, req_byteenable, req_read, req_write, req_writedata,
        output req_waitrequest, req_readdata, req_readdatavalid,
        output avmm_0_rw_address, avmm_0_rw_byteenable, avmm_0_rw_read, avmm_0_rw_write,
        output avmm_0_rw_writedata,
        input  avmm_0_rw_readdata,
        output protocol_err
    );

    modport slave (
        output req_address, req_byteenable, req_read, req_write, req_writedata,
        input  req_waitrequest, req_readdata, req_readdatavalid,
        input  avmm_0_rw_address, avmm_0_rw_byteenable, avmm_0_rw_read, avmm_0_rw_write,
        input  avmm_0_rw_writedata,
        output avmm_0_rw_readdata,
        input  protocol_err
    );
endinterface

// File: rtl/avmm_rw_arbiter.sv
// Round-robin arbiter sharing one 64-bit Avalon-MM read/write port among NUM_REQ requesters.
// Reads are tagged through a fixed-latency pipeline so readdata is steered back to the issuer.
module avmm_rw_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned READ_LATENCY = 2
) (
    input logic               clock,
    input logic               resetn,
    avmm_rw_arbiter_if.master bus
);
    localparam int unsigned IdW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] active;
    logic [NUM_REQ-1:0] grant;
    logic               grant_valid;
    logic [IdW-1:0]     grant_idx;

    logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
    logic [63:0]    addr_q, addr_d;
    logic [63:0]    wdata_q, wdata_d;
    logic [7:0]     be_q, be_d;
    logic           rd_q, rd_d;
    logic           wr_q, wr_d;
    logic           err_q, err_d;

    logic [READ_LATENCY-1:0]          tag_vld_q, tag_vld_d;
    logic [READ_LATENCY-1:0][IdW-1:0] tag_id_q, tag_id_d;
    logic [NUM_REQ-1:0]               rdv_q, rdv_d;

    assign active = bus.req_read | bus.req_write;

    // First active requester at or after rr_ptr, wrapping; nothing is granted in reset.
    always_comb begin
        logic [IdW-1:0] cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IdW'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (resetn && !grant_valid && active[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (grant_valid) grant[grant_idx] = 1'b1;
    end

    assign bus.req_waitrequest = active & ~grant;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        err_d    = err_q | (|(bus.req_read & bus.req_write));
        if (grant_valid) begin
            addr_d   = bus.req_address[{grant_idx, 6'd0} +: 64];
            wdata_d  = bus.req_writedata[{grant_idx, 6'd0} +: 64];
            be_d     = bus.req_byteenable[{grant_idx, 3'd0} +: 8];
            wr_d     = bus.req_write[grant_idx];
            // Read plus write collapses to a write.
            rd_d     = bus.req_read[grant_idx] & ~bus.req_write[grant_idx];
            rr_ptr_d = (grant_idx == IdW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = rd_d;
        tag_id_d[0]  = grant_idx;
        for (int unsigned k = 1; k < READ_LATENCY; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_id_d[k]  = tag_id_q[k-1];
        end
        rdv_d = '0;
        if (tag_vld_q[READ_LATENCY-1]) rdv_d[tag_id_q[READ_LATENCY-1]] = 1'b1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rr_ptr_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
            rdv_q     <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
            rdv_q     <= rdv_d;
        end
    end

    assign bus.avmm_0_rw_address    = addr_q;
    assign bus.avmm_0_rw_byteenable = be_q;
    assign bus.avmm_0_rw_read       = rd_q;
    assign bus.avmm_0_rw_write      = wr_q;
    assign bus.avmm_0_rw_writedata  = wdata_q;
    assign bus.req_readdata         = bus.avmm_0_rw_readdata;
    assign bus.req_readdatavalid    = rdv_q;
    assign bus.protocol_err         = err_q;
endmodule

// File: tb/tb_avmm_rw_arbiter.sv
// Randomized bench for avmm_rw_arbiter: requester and memory models plus a
// transaction-level reference of grants, port commands and tagged read returns.
module tb_avmm_rw_arbiter;
    localparam int unsigned N = 4;
    localparam int unsigned L = 2;

    logic clock = 1'b0;
    logic resetn = 1'b1;
    always #5 clock = ~clock;

    avmm_rw_arbiter_if #(.NUM_REQ(N)) bus ();

    avmm_rw_arbiter #(.NUM_REQ(N), .READ_LATENCY(L)) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Requester state: a pending command is held until accepted.
    logic        pend [N];
    logic        p_rd [N];
    logic        p_wr [N];
    logic [63:0] p_addr [N];
    logic [7:0]  p_be [N];
    logic [63:0] p_wd [N];
    logic [N-1:0] accepted;

    // Generation knobs.
    logic [N-1:0] gen_mask;
    int           gen_prob;
    int           gen_kind;  // 0 random rd/wr, 1 write, 2 read, 3 read+write

    // Reference model.
    int           rr;
    logic         exp_rd, exp_wr, exp_err;
    logic [63:0]  exp_addr, exp_wd;
    logic [7:0]   exp_be;
    logic [N-1:0] exp_rdv [16];
    logic [63:0]  exp_rdata [16];
    logic         mem_v [16];
    logic [63:0]  mem_d [16];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [63:0] mem_hash(input logic [63:0] a);
        return {a[31:0], a[63:32]} ^ 64'hDEAD_BEEF_0000_0001;
    endfunction

    function automatic int model_grant(input logic [N-1:0] act, input int ptr);
        for (int k = 0; k < int'(N); k++) begin
            if (act[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic clear_model();
        rr = 0; exp_rd = 0; exp_wr = 0; exp_err = 0;
        exp_addr = '0; exp_wd = '0; exp_be = '0;
        for (int i = 0; i < 16; i++) begin
            exp_rdv[i] = '0; exp_rdata[i] = '0; mem_v[i] = 0; mem_d[i] = '0;
        end
        for (int i = 0; i < int'(N); i++) pend[i] = 0;
        accepted = '0;
    endtask

    task automatic do_reset();
        logic [N-1:0] rv, wv;
        @(posedge clock); #1;
        resetn = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cyc++;
            rv = N'($urandom);
            wv = N'($urandom) & ~rv;
            bus.req_read  = rv;
            bus.req_write = wv;
            #1;
            check_eq("rst_waitreq", 64'(bus.req_waitrequest), 64'(rv | wv));
            check_eq("rst_rd", 64'(bus.avmm_0_rw_read), 64'(0));
            check_eq("rst_wr", 64'(bus.avmm_0_rw_write), 64'(0));
            check_eq("rst_addr", bus.avmm_0_rw_address, 64'(0));
            check_eq("rst_wd", bus.avmm_0_rw_writedata, 64'(0));
            check_eq("rst_be", 64'(bus.avmm_0_rw_byteenable), 64'(0));
            check_eq("rst_rdv", 64'(bus.req_readdatavalid), 64'(0));
            check_eq("rst_err", 64'(bus.protocol_err), 64'(0));
            @(posedge clock); #1;
        end
        bus.req_read  = '0;
        bus.req_write = '0;
        clear_model();
        resetn = 1'b1;
    endtask

    task automatic step();
        logic [N-1:0]     rd_vec, wr_vec, act, exp_wait, one;
        logic [64*N-1:0]  a_vec, wd_vec;
        logic [8*N-1:0]   be_vec;
        int               g, s, r;
        @(posedge clock); #1;
        cyc++;
        for (int i = 0; i < int'(N); i++) begin
            if (accepted[i]) pend[i] = 0;
            if (!pend[i] && gen_mask[i] && $urandom_range(99) < gen_prob) begin
                pend[i] = 1;
                case (gen_kind)
                    0: begin r = $urandom_range(1); p_rd[i] = (r == 1); p_wr[i] = (r == 0); end
                    1: begin p_rd[i] = 0; p_wr[i] = 1; end
                    2: begin p_rd[i] = 1; p_wr[i] = 0; end
                    default: begin p_rd[i] = 1; p_wr[i] = 1; end
                endcase
                p_addr[i] = {$urandom, $urandom};
                p_be[i]   = 8'($urandom);
                p_wd[i]   = {$urandom, $urandom};
            end
            rd_vec[i] = pend[i] & p_rd[i];
            wr_vec[i] = pend[i] & p_wr[i];
            a_vec[64*i +: 64]  = p_addr[i];
            wd_vec[64*i +: 64] = p_wd[i];
            be_vec[8*i +: 8]   = p_be[i];
        end
        bus.req_read = rd_vec; bus.req_write = wr_vec;
        bus.req_address = a_vec; bus.req_writedata = wd_vec; bus.req_byteenable = be_vec;

        // Memory: answer each observed read strobe L cycles later, garbage otherwise.
        if (bus.avmm_0_rw_read === 1'b1) begin
            s = (cyc + L) % 16;
            mem_v[s] = 1;
            mem_d[s] = mem_hash(bus.avmm_0_rw_address);
        end
        s = cyc % 16;
        bus.avmm_0_rw_readdata = mem_v[s] ? mem_d[s] : {$urandom, $urandom};
        mem_v[s] = 0;
        #1;

        act = rd_vec | wr_vec;
        g = model_grant(act, rr);
        exp_wait = act;
        if (g >= 0) exp_wait[g] = 1'b0;
        check_eq("waitreq", 64'(bus.req_waitrequest), 64'(exp_wait));
        check_eq("port_rd", 64'(bus.avmm_0_rw_read), 64'(exp_rd));
        check_eq("port_wr", 64'(bus.avmm_0_rw_write), 64'(exp_wr));
        check_eq("port_addr", bus.avmm_0_rw_address, exp_addr);
        check_eq("port_wd", bus.avmm_0_rw_writedata, exp_wd);
        check_eq("port_be", 64'(bus.avmm_0_rw_byteenable), 64'(exp_be));
        check_eq("perr", 64'(bus.protocol_err), 64'(exp_err));
        s = cyc % 16;
        check_eq("rdv", 64'(bus.req_readdatavalid), 64'(exp_rdv[s]));
        if (exp_rdv[s] != '0) check_eq("rdata", bus.req_readdata, exp_rdata[s]);
        exp_rdv[s] = '0;

        exp_rd = 0; exp_wr = 0;
        if (g >= 0) begin
            exp_wr   = p_wr[g];
            exp_rd   = p_rd[g] & ~p_wr[g];
            exp_addr = p_addr[g];
            exp_wd   = p_wd[g];
            exp_be   = p_be[g];
            rr       = (g + 1) % N;
            if (exp_rd) begin
                one = '0; one[g] = 1'b1;
                s = (cyc + 1 + L) % 16;
                exp_rdv[s]   = one;
                exp_rdata[s] = mem_hash(p_addr[g]);
            end
        end
        if ((rd_vec & wr_vec) != '0) exp_err = 1;
        accepted = act & ~bus.req_waitrequest;
    endtask

    task automatic run(input logic [N-1:0] mask, input int kind, input int prob, input int n);
        gen_mask = mask; gen_kind = kind; gen_prob = prob;
        for (int c = 0; c < n; c++) step();
    endtask

    initial begin
        bus.req_address = '0; bus.req_byteenable = '0; bus.req_read = '0;
        bus.req_write = '0; bus.req_writedata = '0; bus.avmm_0_rw_readdata = '0;
        clear_model();

        do_reset();
        // Single read by requester 2, then drain.
        run(4'b0100, 2, 100, 1);
        run(4'b0000, 0, 0, 6);

        // Full write contention from reset: fair rotation.
        do_reset();
        run(4'b1111, 1, 100, 16);
        run(4'b0000, 0, 0, 2);

        // Grant to 2 moves rr_ptr to 3; then 1 and 3 alternate starting with 3.
        do_reset();
        run(4'b0100, 1, 100, 1);
        run(4'b1010, 1, 100, 6);
        run(4'b0000, 0, 0, 2);

        // Back-to-back reads from 0 and 1.
        run(4'b0011, 2, 100, 2);
        run(4'b0000, 0, 0, 6);

        // Randomized traffic.
        run(4'b1111, 0, 60, 400);
        run(4'b0000, 0, 0, 6);

        // Read plus write from requester 1: issued as write, sticky error.
        run(4'b0010, 3, 100, 1);
        run(4'b0000, 0, 0, 3);
        run(4'b1111, 0, 50, 60);
        run(4'b0000, 0, 0, 6);

        // Reset one cycle after a read reaches the port: no late readdatavalid.
        do_reset();
        run(4'b0001, 2, 100, 1);
        run(4'b0000, 0, 0, 1);
        do_reset();
        run(4'b0000, 0, 0, 6);
        run(4'b1111, 1, 100, 8);
        run(4'b0000, 0, 0, 4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
